seq_table_counter: RTL and testbench
====================================

Name: seq_table_counter

Overview:
- Parametrised arbitrary-sequence synchronous counter.
- Steps an index through a programmable table of WIDTH-bit codes and outputs the table entry for the current index.
- Generalises the fixed 4-bit custom-sequence counter with:
  - programmable sequence contents and length;
  - forward and reverse direction;
  - wrap or stop at the end of the sequence;
  - synchronous index load.
- Used wherever the lab datapath needs a non-binary count sequence without redesigning JK excitation logic.

Parameters:
- WIDTH, 4, bits per output code.
- DEPTH, 16, maximum sequence length (entries); must be ≥2.
- IDX_W, $clog2(DEPTH), derived index width; do not override.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- dir  in  1  1 = forward (idx+1), 0 = reverse (idx-1).
- wrap_en  in  1  1 = wrap at sequence end, 0 = halt at sequence end.
- prog_we  in  1  table write strobe.
- prog_addr  in  IDX_W  table write address.
- prog_data  in  WIDTH  table write data.
- len_we  in  1  sequence-length write strobe.
- len_data  in  IDX_W+1  new length; legal range 1..DEPTH.
- load  in  1  synchronous index load.
- load_idx  in  IDX_W  index to load.
- q  out  WIDTH  current code; q = table[idx], combinational from registered idx and table.
- idx  out  IDX_W  current index.
- tc  out  1  terminal: idx==len-1 when dir=1, idx==0 when dir=0.
- halted  out  1  counter stopped at sequence end.
- len_err  out  1  one-cycle pulse on an illegal length write.

Behaviour:
- Reset (clear=1, asynchronous, takes effect without a clock edge):
  - idx=0, halted=0, len_err=0, len=DEPTH.
  - table[i] = i mod 2^WIDTH, so q=0.
  - All state is held while clear is high.
- Per-edge priority: clear > len_we > load > count. prog_we is independent of this priority and takes effect on any edge where clear=0.
- Table write: table[prog_addr] ← prog_data at the edge. prog_addr ≥ DEPTH is ignored. A write to the current idx appears on q right after that edge.
- Length write (len_we=1):
  - If 1 ≤ len_data ≤ DEPTH: len ← len_data.
  - If additionally len_data ≤ idx: idx ← 0 and halted ← 0.
  - Otherwise (len_data = 0 or > DEPTH): len unchanged and len_err=1 for the following cycle.
  - Any load or count in the same cycle is suppressed.
- Load (load=1, len_we=0):
  - idx ← min(load_idx, len-1); halted ← 0.
  - Count is suppressed that cycle.
- Count (en=1, halted=0, no len_we, no load):
  - Forward, idx<len-1: idx+1.
  - Forward, idx==len-1: 0 if wrap_en, else hold and halted ← 1.
  - Reverse, idx>0: idx-1.
  - Reverse, idx==0: len-1 if wrap_en, else hold and halted ← 1.
- en=0 or halted=1: idx holds.
- halted is cleared only by clear, load, or a length write that forces idx to 0. Changing dir or wrap_en does not clear it.
- len=1: idx stays 0 and tc=1 in both directions. With wrap_en=1 the count is a self-loop; with wrap_en=0 the first enabled edge sets halted.
- Latency: idx, q, tc and halted reflect a count one edge after en is sampled. There are no multi-cycle operations.
- Reset mid-operation discards the programmed table and length.

Decomposition:
- Package seq_counter_pkg: function for the identity reset value; localparam helpers for IDX_W and LEN_W=IDX_W+1.
- Sub-module seq_table: DEPTH×WIDTH register file with asynchronous identity reset on clear, one synchronous write port, one combinational read port.
- Top level holds the idx/len/halted/len_err registers, next-state logic and tc decode.

Test Plan (WIDTH=4, DEPTH=16):
1. Default sequence: pulse clear, then en=1, dir=1, wrap_en=1 for 17 edges.
   - q = 0,1,…,15,0; tc=1 only while idx=15.
2. Programmed sequence: write table[0..5] = 3,7,1,12,9,0; len_data=6; load idx 0; count forward with wrap.
   - q = 3,7,1,12,9,0,3,7.
3. Halt and recover: as test 2 but wrap_en=0.
   - At idx=5, halted=1 and q stays 0 over 3 further enabled edges.
   - load_idx=2 → q=1, halted=0.
4. Reverse wrap: as test 2, dir=0 from idx=2.
   - idx = 1,0,5,4; q = 7,3,0,9.
5. Length edge cases:
   - idx=4, write len=3 → next idx=0.
   - len_data=0 → len_err high for one cycle, len stays 3.
   - len_we with load same edge → load ignored.
6. Async reset: assert clear between clock edges mid-count.
   - q=0, idx=0, halted=0 immediately, before the next clk edge.
   - Table reads identity afterwards.

Source files
------------

// File: rtl/seq_counter_pkg.sv
// Shared helpers for the table-driven sequence counter: index/length
// width calculation, the identity code loaded into the table on reset,
// and the per-edge action encoding used by the counter's next-state logic.
package seq_counter_pkg;

  // Index width for a table of 'depth' entries (at least one bit).
  function automatic int calc_idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Length register width: one extra bit so that len == DEPTH is representable.
  function automatic int calc_len_w(input int depth);
    return calc_idx_w(depth) + 1;
  endfunction

  // Reset contents of table entry 'entry': its own index modulo 2^width.
  function automatic int identity_code(input int entry, input int width);
    return entry & ((1 << width) - 1);
  endfunction

  // Which operation owns the index on a given edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_LEN   = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_COUNT = 2'd3
  } act_e;

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH code table: identity contents on clear, one synchronous
// write port, one combinational read port.
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int IDX_W = calc_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // One register per entry so each can reset to its own identity code.
  // Addresses at or beyond DEPTH match no entry and are dropped.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Entry gi: identity on clear, otherwise take a matching write.
    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        mem_q[gi] <= WIDTH'(identity_code(gi, WIDTH));
      end else if (we && (waddr == IDX_W'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  // The counter keeps its index below len <= DEPTH, so the read is in range.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_table_counter.sv
// Arbitrary-sequence counter: walks an index through a programmable
// table of codes, forward or reverse, wrapping or halting at the ends,
// with a synchronous load and a run-time sequence length.
module seq_table_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int IDX_W = calc_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [WIDTH-1:0] prog_data,
  input  logic             len_we,
  input  logic [IDX_W:0]   len_data,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             tc,
  output logic             halted,
  output logic             len_err
);

  localparam int LEN_W = IDX_W + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             halted_q, halted_d;
  logic             len_err_q, len_err_d;

  logic [IDX_W-1:0] last_idx;
  logic             len_ok;
  act_e             act;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk   (clk),
    .clear (clear),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (idx_q),
    .rdata (q)
  );

  // len is never 0, so len-1 always fits the index width.
  assign last_idx = IDX_W'(len_q - LEN_W'(1));
  assign len_ok   = (len_data != '0) && (len_data <= LEN_W'(DEPTH));

  // Pick the single operation that owns this edge: length > load > count.
  always_comb begin
    act = ACT_HOLD;
    if (len_we) begin
      act = ACT_LEN;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (en && !halted_q) begin
      act = ACT_COUNT;
    end
  end

  // Next-state for index, length, halt flag and length-error pulse.
  always_comb begin
    idx_d     = idx_q;
    len_d     = len_q;
    halted_d  = halted_q;
    len_err_d = 1'b0;
    unique case (act)
      ACT_LEN: begin
        if (len_ok) begin
          len_d = len_data;
          // Shrinking below the current position restarts the sequence.
          if (len_data <= {1'b0, idx_q}) begin
            idx_d    = '0;
            halted_d = 1'b0;
          end
        end else begin
          len_err_d = 1'b1;
        end
      end
      ACT_LOAD: begin
        idx_d    = (load_idx > last_idx) ? last_idx : load_idx;
        halted_d = 1'b0;
      end
      ACT_COUNT: begin
        if (dir) begin
          if (idx_q == last_idx) begin
            if (wrap_en) idx_d    = '0;
            else         halted_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          if (idx_q == '0) begin
            if (wrap_en) idx_d    = last_idx;
            else         halted_d = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Counter state registers; clear restores a full-length sequence at index 0.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx_q     <= '0;
      len_q     <= LEN_W'(DEPTH);
      halted_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      len_q     <= len_d;
      halted_q  <= halted_d;
      len_err_q <= len_err_d;
    end
  end

  // Terminal decode follows the live direction input.
  always_comb begin
    tc = dir ? (idx_q == last_idx) : (idx_q == '0);
  end

  assign idx     = idx_q;
  assign halted  = halted_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_seq_table_counter.sv
// Scoreboard bench for seq_table_counter (WIDTH=4, DEPTH=16): stimulus
// pushes hand-computed expected outputs, a monitor pops and compares.
module tb_seq_table_counter;

  logic       clk = 1'b0;
  logic       clear, en, dir, wrap_en, prog_we, len_we, load;
  logic [3:0] prog_addr, prog_data, load_idx;
  logic [4:0] len_data;
  logic [3:0] q, idx;
  logic       tc, halted, len_err;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] idx;
    logic       tc;
    logic       halted;
    logic       len_err;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] codes [6];

  seq_table_counter #(.WIDTH(4), .DEPTH(16)) dut (
    .clk       (clk),
    .clear     (clear),
    .en        (en),
    .dir       (dir),
    .wrap_en   (wrap_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .len_we    (len_we),
    .len_data  (len_data),
    .load      (load),
    .load_idx  (load_idx),
    .q         (q),
    .idx       (idx),
    .tc        (tc),
    .halted    (halted),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  // Monitor: whenever outputs are presented, compare against the queue head.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({q, idx, tc, halted, len_err} !== {e.q, e.idx, e.tc, e.halted, e.len_err}) begin
          errors++;
          $display("FAIL %s: got q=%0d idx=%0d tc=%0b halted=%0b len_err=%0b, expected q=%0d idx=%0d tc=%0b halted=%0b len_err=%0b",
                   e.name, q, idx, tc, halted, len_err, e.q, e.idx, e.tc, e.halted, e.len_err);
        end else begin
          $display("check %s: q=%0d idx=%0d tc=%0b halted=%0b len_err=%0b",
                   e.name, q, idx, tc, halted, len_err);
        end
      end
    end
  end

  task automatic push(input string nm, input int eq, input int ei,
                      input bit etc, input bit eh, input bit ee);
    exp_t e;
    e.name = nm; e.q = 4'(eq); e.idx = 4'(ei);
    e.tc = etc; e.halted = eh; e.len_err = ee;
    sb.push_back(e);
    ->sample_ev;
  endtask

  // Check outputs right now, without a clock edge.
  task automatic check_now(input string nm, input int eq, input int ei,
                           input bit etc, input bit eh, input bit ee);
    push(nm, eq, ei, etc, eh, ee);
    #2;
  endtask

  // One clock edge, then expect the given outputs; returns at the negedge.
  task automatic tick(input string nm, input int eq, input int ei,
                      input bit etc, input bit eh, input bit ee);
    @(posedge clk);
    #1;
    push(nm, eq, ei, etc, eh, ee);
    @(negedge clk);
  endtask

  task automatic tick_nc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    codes[0] = 4'd3; codes[1] = 4'd7; codes[2] = 4'd1;
    codes[3] = 4'd12; codes[4] = 4'd9; codes[5] = 4'd0;
    clear = 1'b1; en = 1'b0; dir = 1'b1; wrap_en = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    len_we = 1'b0; len_data = '0; load = 1'b0; load_idx = '0;
    #1;
    check_now("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b0;

    // 1: default identity sequence, forward wrap
    en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick($sformatf("default_%0d", k), k % 16, k % 16, (k % 16) == 15, 0, 0);
    end
    en = 1'b0;

    // 2: programmed 6-entry sequence
    prog_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      prog_addr = 4'(i);
      prog_data = codes[i];
      tick_nc();
    end
    prog_we = 1'b0;
    len_we = 1'b1; len_data = 5'd6;
    tick("len6", 7, 1, 0, 0, 0);
    len_we = 1'b0;
    load = 1'b1; load_idx = 4'd0;
    tick("load0", 3, 0, 0, 0, 0);
    load = 1'b0;
    en = 1'b1;
    tick("prog_1", 7, 1, 0, 0, 0);
    tick("prog_2", 1, 2, 0, 0, 0);
    tick("prog_3", 12, 3, 0, 0, 0);
    tick("prog_4", 9, 4, 0, 0, 0);
    tick("prog_5", 0, 5, 1, 0, 0);
    tick("prog_wrap", 3, 0, 0, 0, 0);
    tick("prog_7", 7, 1, 0, 0, 0);

    // 3: halt at end without wrap, then recover with load
    en = 1'b0; wrap_en = 1'b0;
    load = 1'b1; load_idx = 4'd0;
    tick("h_load0", 3, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    tick("h_1", 7, 1, 0, 0, 0);
    tick("h_2", 1, 2, 0, 0, 0);
    tick("h_3", 12, 3, 0, 0, 0);
    tick("h_4", 9, 4, 0, 0, 0);
    tick("h_5", 0, 5, 1, 0, 0);
    tick("h_halt", 0, 5, 1, 1, 0);
    tick("h_hold1", 0, 5, 1, 1, 0);
    tick("h_hold2", 0, 5, 1, 1, 0);
    dir = 1'b0;
    tick("h_dirflip", 0, 5, 0, 1, 0);
    dir = 1'b1; en = 1'b0;
    load = 1'b1; load_idx = 4'd2;
    tick("h_recover", 1, 2, 0, 0, 0);
    load = 1'b0;

    // 4: reverse with wrap from idx 2
    wrap_en = 1'b1; dir = 1'b0; en = 1'b1;
    tick("rev_1", 7, 1, 0, 0, 0);
    tick("rev_0", 3, 0, 1, 0, 0);
    tick("rev_wrap", 0, 5, 0, 0, 0);
    tick("rev_4", 9, 4, 0, 0, 0);
    en = 1'b0;
    load = 1'b1; load_idx = 4'd9;
    tick("load_clamp", 0, 5, 0, 0, 0);

    // 5: length edge cases
    load_idx = 4'd4;
    tick("load4", 9, 4, 0, 0, 0);
    load = 1'b0;
    len_we = 1'b1; len_data = 5'd3;
    tick("len3_restart", 3, 0, 1, 0, 0);
    len_data = 5'd0;
    tick("len0_err", 3, 0, 1, 0, 1);
    len_we = 1'b0;
    tick("len_err_clr", 3, 0, 1, 0, 0);
    dir = 1'b1; load = 1'b1; load_idx = 4'd15;
    tick("len3_kept", 1, 2, 1, 0, 0);
    len_we = 1'b1; len_data = 5'd6; load_idx = 4'd0;
    tick("len_over_load", 1, 2, 0, 0, 0);
    load = 1'b0; len_data = 5'd17;
    tick("len17_err", 1, 2, 0, 0, 1);
    len_data = 5'd1;
    tick("len1", 3, 0, 1, 0, 0);
    len_we = 1'b0; en = 1'b1; wrap_en = 1'b1;
    tick("len1_loop", 3, 0, 1, 0, 0);
    wrap_en = 1'b0;
    tick("len1_halt", 3, 0, 1, 1, 0);
    en = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'd10;
    tick("wr_cur_idx", 10, 0, 1, 1, 0);
    prog_we = 1'b0;

    // 6: asynchronous clear mid-count
    len_we = 1'b1; len_data = 5'd16;
    tick_nc();
    len_we = 1'b0;
    load = 1'b1; load_idx = 4'd3;
    tick("a_load3", 12, 3, 0, 0, 0);
    load = 1'b0; en = 1'b1; wrap_en = 1'b1;
    tick("a_4", 9, 4, 0, 0, 0);
    tick("a_5", 0, 5, 0, 0, 0);
    tick("a_6", 6, 6, 0, 0, 0);
    #1;
    clear = 1'b1;
    #1;
    check_now("async_clear", 0, 0, 0, 0, 0);
    tick("clear_held", 0, 0, 0, 0, 0);
    clear = 1'b0; en = 1'b0;
    load = 1'b1; load_idx = 4'd3;
    tick("ident_3", 3, 3, 0, 0, 0);
    load_idx = 4'd5;
    tick("ident_5", 5, 5, 0, 0, 0);
    load_idx = 4'd0;
    tick("ident_0", 0, 0, 0, 0, 0);
    load = 1'b0;

    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
